// File: rtl/my_prog_loader_if.sv
// Loader byte stream and CPU fetch port for my_prog_loader.
// The master side drives the byte stream and fetch address; the slave is the loader.
interface my_prog_loader_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  IN_DATA;
    logic        IN_LAST;
    logic [15:0] ADDR;
    logic [15:0] DATA;

    modport master (
        output IN_VALID, IN_DATA, IN_LAST, ADDR,
        input  IN_READY, DATA
    );

    modport slave (
        input  IN_VALID, IN_DATA, IN_LAST, ADDR,
        output IN_READY, DATA
    );
endinterface

// File: rtl/my_prog_loader.sv
// Program loader: streams bytes into a small program memory and serves 16-bit big-endian fetches.
// Define MY_PROG_LOADER_CLEAR_EN to zero the whole memory before each load.
module my_prog_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          CK,
    input  logic          RST_N,
    input  logic          START,
    my_prog_loader_if.slave bus,
    output logic          CPU_RUN,
    output logic          BUSY,
    output logic          ERR_OVF,
    output logic [AW:0]   COUNT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_PAD,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW:0]     count_q, count_d;
    logic            err_q, err_d;

    logic [7:0]      mem_q [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [7:0]      mem_wd;

    logic            in_ready;
    logic            xfer;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   rd_addr_next;
    logic            unused_addr_bits;

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            wp_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Memory has no reset so a reset mid-load keeps what was already written.
    always_ff @(posedge CK) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign xfer = bus.IN_VALID & in_ready;

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        count_d = count_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        mem_wa  = wp_q;
        mem_wd  = bus.IN_DATA;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    wp_d    = '0;
                    count_d = '0;
                    err_d   = 1'b0;
`ifdef MY_PROG_LOADER_CLEAR_EN
                    state_d = ST_CLEAR;
`else
                    state_d = ST_LOAD;
`endif
                end
            end
`ifdef MY_PROG_LOADER_CLEAR_EN
            // WP doubles as the clear pointer; it wraps back to 0 for the load.
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_wd = 8'h00;
                wp_d   = wp_q + AW'(1);
                if (wp_q == AW'(DEPTH - 1)) begin
                    state_d = ST_LOAD;
                end
            end
`endif
            ST_LOAD: begin
                if (xfer) begin
                    mem_we  = 1'b1;
                    wp_d    = wp_q + AW'(1);
                    count_d = count_q + (AW + 1)'(1);
                    if (bus.IN_LAST) begin
                        state_d = wp_q[0] ? ST_DONE : ST_PAD;
                    end else if (wp_q == AW'(DEPTH - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAD: begin
                mem_we  = 1'b1;
                mem_wd  = 8'h00;
                wp_d    = wp_q + AW'(1);
                count_d = count_q + (AW + 1)'(1);
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!RST_N) begin
            mem_we = 1'b0;
        end
    end

    always_comb begin
        in_ready = (state_q == ST_LOAD);
        CPU_RUN  = (state_q == ST_DONE);
        BUSY     = (state_q == ST_CLEAR) || (state_q == ST_LOAD) || (state_q == ST_PAD);
    end

    // Fetch reads the array directly, so a same-cycle write shows only after the edge.
    assign rd_addr          = bus.ADDR[AW-1:0];
    assign rd_addr_next     = rd_addr + AW'(1);
    assign bus.DATA         = {mem_q[rd_addr], mem_q[rd_addr_next]};
    assign bus.IN_READY     = in_ready;
    assign COUNT            = count_q;
    assign ERR_OVF          = err_q;
    assign unused_addr_bits = ^bus.ADDR[15:AW];

endmodule

// File: tb/tb_my_prog_loader.sv
// Directed self-checking bench for my_prog_loader (DEPTH=64), valid with or without
// MY_PROG_LOADER_CLEAR_EN.
module tb_my_prog_loader;

    logic       CK;
    logic       RST_N;
    logic       START;
    logic       CPU_RUN;
    logic       BUSY;
    logic       ERR_OVF;
    logic [6:0] COUNT;

    int num_vectors;
    int num_miscompares;

    logic [7:0]  prog_rand [6];
    logic [15:0] word;
    int          waited;

    my_prog_loader_if bus ();

    my_prog_loader #(.DEPTH(64), .AW(6)) dut (
        .CK      (CK),
        .RST_N   (RST_N),
        .START   (START),
        .bus     (bus),
        .CPU_RUN (CPU_RUN),
        .BUSY    (BUSY),
        .ERR_OVF (ERR_OVF),
        .COUNT   (COUNT)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_vectors++;
        if (got !== exp) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic startLoad();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Waits (bounded) for IN_READY, then transfers one byte.
    task automatic sendByte(input logic [7:0] data, input logic last, output int waits);
        waits = 0;
        while (!bus.IN_READY && waits < 200) begin
            tick();
            waits++;
        end
        checkOutput("in_ready_wait", {31'd0, bus.IN_READY}, 32'd1);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = data;
        bus.IN_LAST  = last;
        tick();
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
    endtask

    task automatic readWord(input logic [15:0] addr, output logic [15:0] w);
        bus.ADDR = addr;
        #1;
        w = bus.DATA;
    endtask

    initial begin
        num_vectors     = 0;
        num_miscompares = 0;
        RST_N        = 1'b0;
        START        = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = 8'h00;
        bus.IN_LAST  = 1'b0;
        bus.ADDR     = 16'h0000;
        tick();
        tick();

        // Reset state
        checkOutput("rst_cpu_run", {31'd0, CPU_RUN}, 32'd0);
        checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, bus.IN_READY}, 32'd0);
        checkOutput("rst_err", {31'd0, ERR_OVF}, 32'd0);
        checkOutput("rst_count", {25'd0, COUNT}, 32'd0);
        RST_N = 1'b1;
        tick();

        // Even-length program
        startLoad();
        checkOutput("p1_busy", {31'd0, BUSY}, 32'd1);
        sendByte(8'h01, 1'b0, waited);
        sendByte(8'hA0, 1'b0, waited);
        sendByte(8'h06, 1'b0, waited);
        sendByte(8'h24, 1'b1, waited);
        checkOutput("p1_cpu_run", {31'd0, CPU_RUN}, 32'd1);
        checkOutput("p1_busy_done", {31'd0, BUSY}, 32'd0);
        checkOutput("p1_in_ready", {31'd0, bus.IN_READY}, 32'd0);
        checkOutput("p1_count", {25'd0, COUNT}, 32'd4);
        readWord(16'd0, word);
        checkOutput("p1_data0", {16'd0, word}, 32'h01A0);
        readWord(16'd2, word);
        checkOutput("p1_data2", {16'd0, word}, 32'h0624);

        // Odd-length program gets a pad byte
        startLoad();
        checkOutput("p2_cpu_run_drop", {31'd0, CPU_RUN}, 32'd0);
        sendByte(8'h0B, 1'b0, waited);
        sendByte(8'hCC, 1'b0, waited);
        sendByte(8'h09, 1'b1, waited);
        checkOutput("p2_pad_busy", {31'd0, BUSY}, 32'd1);
        checkOutput("p2_pad_count", {25'd0, COUNT}, 32'd3);
        tick();
        checkOutput("p2_cpu_run", {31'd0, CPU_RUN}, 32'd1);
        checkOutput("p2_count", {25'd0, COUNT}, 32'd4);
        readWord(16'd0, word);
        checkOutput("p2_data0", {16'd0, word}, 32'h0BCC);
        readWord(16'd2, word);
        checkOutput("p2_data2", {16'd0, word}, 32'h0900);

        // Reset in the middle of a load
        startLoad();
        sendByte(8'h11, 1'b0, waited);
        sendByte(8'h22, 1'b0, waited);
        sendByte(8'h33, 1'b0, waited);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        checkOutput("mr_in_ready", {31'd0, bus.IN_READY}, 32'd0);
        checkOutput("mr_busy", {31'd0, BUSY}, 32'd0);
        checkOutput("mr_cpu_run", {31'd0, CPU_RUN}, 32'd0);
        checkOutput("mr_count", {25'd0, COUNT}, 32'd0);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 8'hFF;
        tick();
        tick();
        tick();
        bus.IN_VALID = 1'b0;
        checkOutput("mr_idle_count", {25'd0, COUNT}, 32'd0);
        readWord(16'd0, word);
        checkOutput("mr_data0", {16'd0, word}, 32'h1122);
        readWord(16'd2, word);
        checkOutput("mr_data2", {16'd0, word}, 32'h3300);

        // Random IN_VALID with START held high throughout the load
        prog_rand[0] = 8'hA1; prog_rand[1] = 8'hB2; prog_rand[2] = 8'hC3;
        prog_rand[3] = 8'hD4; prog_rand[4] = 8'hE5; prog_rand[5] = 8'hF6;
        START = 1'b1;
        tick();
        begin
            int idx;
            int guard;
            logic v;
            logic rdy;
            idx   = 0;
            guard = 0;
            while (idx < 6 && guard < 400) begin
                v            = 1'($urandom_range(0, 1));
                bus.IN_VALID = v;
                bus.IN_DATA  = v ? prog_rand[idx] : 8'hEE;
                bus.IN_LAST  = (idx == 5);
                rdy          = bus.IN_READY;
                tick();
                if (v && rdy) idx++;
                if (idx == 6) START = 1'b0;
                guard++;
            end
            bus.IN_VALID = 1'b0;
            bus.IN_LAST  = 1'b0;
            START        = 1'b0;
            checkOutput("rv_bytes_sent", idx, 32'd6);
        end
        checkOutput("rv_cpu_run", {31'd0, CPU_RUN}, 32'd1);
        checkOutput("rv_count", {25'd0, COUNT}, 32'd6);
        readWord(16'd0, word);
        checkOutput("rv_data0", {16'd0, word}, 32'hA1B2);
        readWord(16'd2, word);
        checkOutput("rv_data2", {16'd0, word}, 32'hC3D4);
        readWord(16'd4, word);
        checkOutput("rv_data4", {16'd0, word}, 32'hE5F6);
        tick();
        checkOutput("rv_stays_done", {31'd0, CPU_RUN}, 32'd1);

        // Overflow: 64 bytes without IN_LAST
        startLoad();
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = (i == 0) ? 8'h55 : (i == 63) ? 8'hAA : 8'(i);
            sendByte(b, 1'b0, waited);
            if (i == 62) begin
                checkOutput("ov_err_early", {31'd0, ERR_OVF}, 32'd0);
                checkOutput("ov_count63", {25'd0, COUNT}, 32'd63);
            end
        end
        checkOutput("ov_err", {31'd0, ERR_OVF}, 32'd1);
        checkOutput("ov_cpu_run", {31'd0, CPU_RUN}, 32'd1);
        checkOutput("ov_count", {25'd0, COUNT}, 32'd64);
        checkOutput("ov_in_ready", {31'd0, bus.IN_READY}, 32'd0);
        readWord(16'd63, word);
        checkOutput("ov_wrap63", {16'd0, word}, 32'hAA55);
        readWord(16'd62, word);
        checkOutput("ov_data62", {16'd0, word}, 32'h3EAA);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("ov_err_hold", {31'd0, ERR_OVF}, 32'd1);

        // Reload a 2-byte program over the old contents
        startLoad();
        checkOutput("rl_err_clr", {31'd0, ERR_OVF}, 32'd0);
        checkOutput("rl_count_clr", {25'd0, COUNT}, 32'd0);
        sendByte(8'h77, 1'b0, waited);
`ifdef MY_PROG_LOADER_CLEAR_EN
        checkOutput("rl_clear_cycles", waited, 32'd64);
`else
        checkOutput("rl_clear_cycles", waited, 32'd0);
`endif
        sendByte(8'h88, 1'b1, waited);
        checkOutput("rl_cpu_run", {31'd0, CPU_RUN}, 32'd1);
        checkOutput("rl_count", {25'd0, COUNT}, 32'd2);
        readWord(16'd0, word);
        checkOutput("rl_data0", {16'd0, word}, 32'h7788);
        readWord(16'd2, word);
`ifdef MY_PROG_LOADER_CLEAR_EN
        checkOutput("rl_data2", {16'd0, word}, 32'h0000);
`else
        checkOutput("rl_data2", {16'd0, word}, 32'h0203);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule

// File: doc/my_prog_loader.md
MY_PROG_LOADER -- requirements
Module: my_prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the program memory size in bytes (power of two).
REQ-002 SHALL have parameter AW, default 6, meaning the byte-address width, log2(DEPTH).
REQ-003 SHALL have port CK  input  1  the single clock; all state changes on the posedge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port START  input  1  requests a new load, sampled in IDLE or DONE.
REQ-006 SHALL have port IN_VALID  input  1  the loader byte stream valid.
REQ-007 SHALL have port IN_READY  output  1  the loader can accept a byte.
REQ-008 SHALL have port IN_DATA  input  8  the program byte, big-endian order (high byte of each instruction first).
REQ-009 SHALL have port IN_LAST  input  1  marks the final byte of the program.
REQ-010 SHALL have port ADDR  input  16  the CPU fetch byte address; only ADDR[AW-1:0] is used.
REQ-011 SHALL have port DATA  output  16  the fetched instruction word.
REQ-012 SHALL have port CPU_RUN  output  1  high only in DONE, enabling PC advance.
REQ-013 SHALL have port BUSY  output  1  high in CLEAR, LOAD and PAD.
REQ-014 SHALL have port ERR_OVF  output  1  the program exceeded DEPTH bytes.
REQ-015 SHALL have port COUNT  output  AW+1  the number of bytes written by the current or last load, including any pad byte.

Function
REQ-016 SHALL implement states IDLE, CLEAR, LOAD, PAD and DONE.
REQ-017 IDLE, or DONE, with START=1 SHALL set the write pointer WP to 0, COUNT to 0 and ERR_OVF to 0, then go to CLEAR (macro defined) or LOAD (macro undefined).
REQ-018 IN_READY SHALL be 1 only in LOAD; IN_VALID in any other state SHALL be ignored and SHALL NOT write memory.
REQ-019 A transfer SHALL occur on a posedge with IN_VALID=1 and IN_READY=1: mem[WP] <= IN_DATA, WP <= WP+1, COUNT <= COUNT+1.
REQ-020 On a transfer with IN_LAST=1 and WP even (odd total byte count), the block SHALL go to PAD.
REQ-021 PAD SHALL last one cycle, write 8'h00 to mem[WP], increment COUNT, then go to DONE.
REQ-022 On a transfer with IN_LAST=1 and WP odd, the block SHALL go to DONE.
REQ-023 On a transfer at WP=DEPTH-1 with IN_LAST=0, the block SHALL write the byte, set ERR_OVF=1 and go to DONE; ERR_OVF SHALL hold until the next START or reset.
REQ-024 START SHALL be ignored in CLEAR, LOAD and PAD.
REQ-025 DATA SHALL be combinational: {mem[ADDR[AW-1:0]], mem[(ADDR[AW-1:0]+1) mod DEPTH]}, valid in every state.
REQ-026 The high-byte read at address DEPTH-1 SHALL wrap the low byte to mem[0].
REQ-027 A write and a read of the same byte in the same cycle SHALL return the old value on DATA until the posedge.
REQ-028 CPU_RUN SHALL drop in the cycle after START is accepted in DONE.

Reset
REQ-029 RST_N=0 at a posedge SHALL force state IDLE, WP=0, COUNT=0, ERR_OVF=0, CPU_RUN=0, BUSY=0 and IN_READY=0.
REQ-030 Reset SHALL NOT alter memory contents; a reset mid-load SHALL keep bytes already written and abandon the load.

Configuration
REQ-031 With macro MY_PROG_LOADER_CLEAR_EN defined, CLEAR SHALL write 8'h00 to one byte per cycle, addresses 0..DEPTH-1, then enter LOAD (DEPTH cycles).
REQ-032 Without MY_PROG_LOADER_CLEAR_EN, CLEAR SHALL not exist, START SHALL go directly to LOAD, and prior contents beyond the new program SHALL be retained.

Verification
REQ-033 Reset, pulse START, stream bytes 01,A0,06,24 with IN_LAST on 24 -> DONE, COUNT=4, DATA@0=16'h01A0, DATA@2=16'h0624, CPU_RUN=1.
REQ-034 Stream 0B,CC,09 with IN_LAST on 09 -> PAD writes 00, COUNT=4, DATA@2=16'h0900.
REQ-035 Stream 64 bytes with IN_LAST=0 throughout -> ERR_OVF=1, DONE, COUNT=64; preload mem[63]=AA, mem[0]=55 -> DATA@63=16'hAA55.
REQ-036 Drop RST_N for one cycle after 3 bytes of a load -> IDLE, IN_READY=0, the 3 bytes are retained, and a later IN_VALID writes nothing.
REQ-037 Toggle IN_VALID randomly and hold START=1 throughout LOAD -> bytes are written only on handshake cycles, and START has no effect.
REQ-038 Reload a 2-byte program over a 4-byte one -> with MY_PROG_LOADER_CLEAR_EN, DATA@2=16'h0000 after 64 CLEAR cycles; without it, DATA@2 keeps its old value.
